// File: rtl/alsu_seg_display.sv
// alsu_seg_display: shows the registered 6-bit ALSU result on a 4-digit
// multiplexed seven-segment display.
//   digits 3..2 : result in hex
//   digits 1..0 : result in decimal
// A sequential double-dabble converts binary to BCD. A refresh counter scans
// the digits.
// Optional build macro LEAD_ZERO_BLANK_EN: when defined, a zero in digit 3 or
// digit 1 is shown as blank.
module alsu_seg_display #(
  parameter int REFRESH_DIV    = 100000,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] result,
  input  logic       result_valid,
  input  logic       err,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam int               CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  // XOR mask that converts an active-high glyph to the pin polarity.
  // It also serves as the "all off" pattern.
  localparam logic [6:0]       SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic             DP_OFF  = ACTIVE_LOW_SEG;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  conv_state_t      state;
  logic [5:0]       load_val;
  logic [5:0]       shift_bin;
  logic [7:0]       bcd;
  logic [2:0]       iter;
  logic [5:0]       disp_hex;
  logic [3:0]       disp_tens;
  logic [3:0]       disp_ones;
  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_sel;

  logic [3:0]       ones_adj;
  logic [3:0]       tens_adj;
  logic [13:0]      dd_shift;
  logic [3:0]       nib;
  logic             blank;
  logic [6:0]       glyph_ah;
  logic             dp_on;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift the
  // combined {bcd, binary} register left by one bit.
  always_comb begin
    ones_adj = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    tens_adj = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    dd_shift = {tens_adj, ones_adj, shift_bin} << 1;
  end

  // Conversion FSM:
  //   1. load on a strobe while idle;
  //   2. six shift iterations;
  //   3. one cycle to publish the hex and BCD digits to the display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      load_val  <= '0;
      shift_bin <= '0;
      bcd       <= '0;
      iter      <= '0;
      busy      <= 1'b0;
      disp_hex  <= '0;
      disp_tens <= '0;
      disp_ones <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (result_valid) begin
            load_val  <= result;
            shift_bin <= result;
            bcd       <= '0;
            iter      <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd       <= dd_shift[13:6];
          shift_bin <= dd_shift[5:0];
          iter      <= iter + 3'd1;
          if (iter == 3'd5) state <= DONE;
        end
        DONE: begin
          disp_hex  <= load_val;
          disp_tens <= bcd[7:4];
          disp_ones <= bcd[3:0];
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refresh timer: holds each digit for REFRESH_DIV cycles, then moves to the
  // next digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_sel   <= 2'd0;
    end else if (refresh_cnt == CNT_MAX) begin
      refresh_cnt <= '0;
      digit_sel   <= digit_sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Select the glyph for the currently scanned digit. The error pattern
  // replaces the number.
  always_comb begin
    nib      = 4'd0;
    blank    = 1'b0;
    glyph_ah = 7'h00;
    dp_on    = 1'b0;
    case (digit_sel)
      2'd0:    nib = disp_ones;
      2'd1:    nib = disp_tens;
      2'd2:    nib = disp_hex[3:0];
      default: nib = {2'b00, disp_hex[5:4]};
    endcase
`ifdef LEAD_ZERO_BLANK_EN
    blank = ((digit_sel == 2'd3) || (digit_sel == 2'd1)) && (nib == 4'd0);
`else
    blank = 1'b0;
`endif
    if (err) begin
      case (digit_sel)
        2'd3:    glyph_ah = 7'h00;
        2'd2:    glyph_ah = 7'h79;
        default: glyph_ah = 7'h50;
      endcase
    end else begin
      glyph_ah = blank ? 7'h00 : hex_glyph(nib);
      dp_on    = (digit_sel == 2'd2);
    end
  end

  // Register the pin-level outputs, applying the segment polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= 4'b1111;
    end else begin
      seg <= glyph_ah ^ SEG_OFF;
      dp  <= dp_on ^ DP_OFF;
      an  <= ~(4'b0001 << digit_sel);
    end
  end

endmodule

// File: tb/tb_alsu_seg_display.sv
// tb_alsu_seg_display: self-checking bench for alsu_seg_display.
// Configuration: REFRESH_DIV=4, active-low segments.
// The bench also honours LEAD_ZERO_BLANK_EN when that macro is defined.
module tb_alsu_seg_display;

  localparam int REFRESH_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] result = '0;
  logic       result_valid = 1'b0;
  logic       err = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  int compared = 0;
  int mismatched = 0;
  int edge_cnt;

  typedef struct {
    string           name;
    logic [5:0]      value;
    logic            err;
    logic [3:0][6:0] exp_seg;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  alsu_seg_display #(.REFRESH_DIV(REFRESH_DIV), .ACTIVE_LOW_SEG(1'b1)) dut (
    .clk(clk), .rst(rst), .result(result), .result_valid(result_valid),
    .err(err), .seg(seg), .dp(dp), .an(an), .busy(busy)
  );

  // Clock edges since the last reset release; this sets the expected scan phase.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[d];
  endfunction

  // Reference model: pin-level (active-low) segments for digit k.
  function automatic logic [6:0] modelSeg(input int v, input bit e, input int k);
    int d [4];
    logic [6:0] g;
    d[0] = v % 10;
    d[1] = v / 10;
    d[2] = v % 16;
    d[3] = v / 16;
    if (e) begin
      if (k == 3)      g = 7'h00;
      else if (k == 2) g = 7'h79;
      else             g = 7'h50;
    end else begin
      g = glyph(d[k]);
`ifdef LEAD_ZERO_BLANK_EN
      if ((k == 3 || k == 1) && d[k] == 0) g = 7'h00;
`endif
    end
    return g ^ 7'h7F;
  endfunction

  function automatic logic [3:0][6:0] modelDigits(input int v, input bit e);
    logic [3:0][6:0] r;
    for (int k = 0; k < 4; k++) r[k] = modelSeg(v, e, k);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load a value and check that busy stays high for exactly 7 cycles.
  task automatic applyStimulus(input logic [5:0] v, input logic e);
    int n;
    @(negedge clk);
    result = v;
    result_valid = 1'b1;
    err = e;
    @(negedge clk);
    result_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", n, 7);
  endtask

  // Check a full scan (4 digits x REFRESH_DIV cycles) of {an, seg, dp}.
  task automatic checkOutput(input string name, input logic [3:0][6:0] exp_seg, input bit e);
    int k;
    logic [3:0] exp_an;
    logic       exp_dp;
    repeat (4 * REFRESH_DIV) begin
      @(posedge clk);
      @(negedge clk);
      k = ((edge_cnt - 1) / REFRESH_DIV) % 4;
      exp_an = ~(4'b0001 << k);
      exp_dp = (k == 2 && !e) ? 1'b0 : 1'b1;
      check(name, {20'd0, an, seg, dp}, {20'd0, exp_an, exp_seg[k], exp_dp});
    end
  endtask

  task automatic checkResetState(input string name);
    check(name, {20'd0, an, seg, dp}, {20'd0, 4'b1111, 7'h7F, 1'b1});
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic [5:0] v;
    bit e;

`ifdef LEAD_ZERO_BLANK_EN
    vecs.push_back('{"lzb_5",   6'd5,  1'b0, {7'h7F, 7'h12, 7'h7F, 7'h12}});
    vecs.push_back('{"lzb_16",  6'd16, 1'b0, {7'h79, 7'h40, 7'h79, 7'h02}});
    vecs.push_back('{"lzb_45",  6'd45, 1'b0, {7'h24, 7'h21, 7'h19, 7'h12}});
    vecs.push_back('{"lzb_err", 6'd45, 1'b1, {7'h7F, 7'h06, 7'h2F, 7'h2F}});
`else
    vecs.push_back('{"val_45",  6'd45, 1'b0, {7'h24, 7'h21, 7'h19, 7'h12}});
    vecs.push_back('{"val_63",  6'd63, 1'b0, {7'h30, 7'h0E, 7'h02, 7'h30}});
    vecs.push_back('{"val_0",   6'd0,  1'b0, {7'h40, 7'h40, 7'h40, 7'h40}});
    vecs.push_back('{"val_9",   6'd9,  1'b0, {7'h40, 7'h10, 7'h40, 7'h10}});
    vecs.push_back('{"val_58",  6'd58, 1'b0, {7'h30, 7'h08, 7'h12, 7'h00}});
    vecs.push_back('{"err_ld",  6'd45, 1'b1, {7'h7F, 7'h06, 7'h2F, 7'h2F}});
`endif

    // Reset state, then the scan pattern after release.
    repeat (3) @(negedge clk);
    checkResetState("reset_init");
    rst = 1'b0;
    checkOutput("post_reset_scan", modelDigits(0, 0), 0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].value, vecs[i].err);
      checkOutput(vecs[i].name, vecs[i].exp_seg, vecs[i].err);
    end

    // Reset asserted while 45 is displayed.
    applyStimulus(6'd45, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("reset_mid_op");
    rst = 1'b0;
    checkOutput("reset_mid_op_scan", modelDigits(0, 0), 0);

    // A load while busy is ignored.
    @(negedge clk);
    result = 6'd63;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (2) @(negedge clk);
    result = 6'd0;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy_ignore_len", n, 4);
    repeat (2) @(negedge clk);
    check("no_requeue_busy", {31'd0, busy}, 32'd0);
    checkOutput("ignore_load", modelDigits(63, 0), 0);

    // err held for 20 cycles over a displayed value, then released.
    applyStimulus(6'd45, 1'b0);
    @(negedge clk);
    err = 1'b1;
    checkOutput("err_hold", modelDigits(45, 1), 1);
    repeat (4) @(negedge clk);
    err = 1'b0;
    checkOutput("err_release", modelDigits(45, 0), 0);

    // Reset 3 cycles into a conversion aborts it.
    applyStimulus(6'd63, 1'b0);
    @(negedge clk);
    result = 6'd45;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_mid_conv", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("reset_mid_conv");
    rst = 1'b0;
    checkOutput("abort_scan", modelDigits(0, 0), 0);
    check("abort_busy", {31'd0, busy}, 32'd0);

    // Random loads, sometimes with err asserted, checked against the model.
    for (int i = 0; i < 24; i++) begin
      v = 6'($urandom_range(0, 63));
      e = ($urandom_range(0, 3) == 0);
      applyStimulus(v, e);
      checkOutput("random", modelDigits(int'(v), e), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alsu_seg_display.md
Name: alsu_seg_display

Overview:
Output stage directly downstream of the ALSU. Consumes the registered 6-bit ALSU result and an error level, and shows them on a 4-digit multiplexed seven-segment display. Digits 3..2 show the result in hex; digits 1..0 show it in decimal. A sequential double-dabble unit does the binary-to-BCD conversion, and a refresh counter scans the digits.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays enabled (min 1)
ACTIVE_LOW_SEG, 1, 1 = seg/dp active-low; 0 = active-high (an is always active-low)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
result  in  6  ALSU output value, unsigned 0..63
result_valid  in  1  single-cycle load strobe for result
err  in  1  ALSU invalid/error level
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point
an  out  4  digit enables, one-hot active-low
busy  out  1  conversion in progress

Behaviour:
- Reset values: an=4'b1111, seg=all off (7'h7F if ACTIVE_LOW_SEG=1, else 7'h00), dp off, busy=0.
- Reset values, internal: shown value=0, digit select=0, refresh counter=0.
- All outputs are registered. On the first clk edge after rst deasserts, an=4'b1110 and digit 0 is driven.
- Conversion FSM states:
  - IDLE: result_valid=1 latches result, clears the BCD accumulator, sets busy=1, then goes to SHIFT.
  - SHIFT: runs exactly 6 iterations, one per cycle. Each iteration does add-3 on any BCD nibble >=5, then a shift left.
  - SHIFT -> DONE after the 6th iteration.
  - DONE: copies the hex and BCD digits into the display registers in one cycle, clears busy, returns to IDLE.
- busy is high for 7 cycles in total.
- result_valid while busy=1 is ignored. No queueing.
- Until DONE, the display keeps showing the previous value.
- Digit map:
  - d3 = result[5:4] in hex (0..3).
  - d2 = result[3:0] in hex (0..F).
  - d1 = decimal tens (0..6).
  - d0 = decimal ones.
- dp is lit only while digit 2 is enabled, to separate the hex and decimal fields.
- Refresh: counter runs 0..REFRESH_DIV-1. At terminal count, digit select advances 0->1->2->3->0 and the counter wraps to 0.
- Digit k gives an = ~(4'b0001<<k). With REFRESH_DIV=1, the digit advances every cycle.
- Active-high glyphs:
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Hex letters: A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Others: r=50, blank=00.
  - For ACTIVE_LOW_SEG=1, seg = glyph ^ 7'h7F.
- err=1 overrides the displayed content: d3=blank, d2=E, d1=r, d0=r, dp off.
  - err is sampled every cycle. The conversion still proceeds and updates the display registers.
  - When err returns to 0, the latest converted value appears on the next digit drive.
- err and result_valid in the same cycle: the load is accepted and the error glyphs are shown.
- rst mid-conversion: aborts the conversion, returns to reset values; the display shows 0 after release.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: d3 is blanked when it is 0. d1 is blanked when it is 0. d2 and d0 are always shown.
- Not defined: all four digits always shown, including leading zeros.

Test Plan:
Bench settings unless noted: REFRESH_DIV=4, ACTIVE_LOW_SEG=1, macro undefined.
1. Reset asserted mid-operation -> an=1111, seg=7F, busy=0. After release, an=1110, seg=40 ('0'). an sequence 1110,1101,1011,0111, each held 4 cycles.
2. result=45, result_valid pulse -> busy=1 for 7 cycles. Then:
   - d0 seg=12 ('5'), d1=19 ('4'), d2=21 ('d'), d3=24 ('2').
   - dp=0 only on digit 2.
3. result=63 loaded, result=0 pulsed 3 cycles later (still busy) -> second load ignored. Display shows d3=30 ('3'), d2=0E ('F'), d1=02 ('6'), d0=30 ('3').
4. err=1 for 20 cycles after 45 is displayed -> d3=7F, d2=06 ('E'), d1=2F, d0=2F ('r'). After err=0, the 45 pattern returns.
5. rst pulsed 3 cycles into converting 45 -> busy=0. All digits show '0' (40) after release.
6. LEAD_ZERO_BLANK_EN defined, result=5 -> d3=7F, d2=12, d1=7F, d0=12. result=16 -> d3=79 ('1'), d2=40, d1=79, d0=02 ('6').
